id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
Parametrised successor to the ID/EX pipeline register. It carries decode-stage control fields (WB, M, EX), operand data, the immediate and register specifiers into the execute stage. Unlike a plain always-load register, it adds:
- a valid/ready handshake on both sides, so the hazard unit can stall either stage
- a two-entry skid buffer, so in_ready can be driven from a register
- a flush input that inserts a bubble
- bubble control-zeroing

Parameters:
DATA_W, 32, width of DataA, DataB, imm_value
REG_W, 5, width of RegRs/RegRt/RegRd
WB_W, 2, width of WB control field
M_W, 3, width of M control field
EX_W, 4, width of EX control field
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry, combinational in_ready

Ports:
clock  input  1  pipeline clock, all state on posedge
reset  input  1  synchronous, active-high
flush  input  1  discard all held and incoming beats this cycle
in_valid  input  1  ID stage presents a beat
in_ready  output  1  stage can accept a beat
WB, M, EX  input  WB_W/M_W/EX_W  control fields from decode
DataA, DataB, imm_value  input  DATA_W each  operands and sign-extended immediate
RegRs, RegRt, RegRd  input  REG_W each  register specifiers
out_valid  output  1  EX stage beat valid
out_ready  input  1  EX stage accepts beat
WBreg, Mreg, EXreg  output  WB_W/M_W/EX_W  registered control fields
DataAreg, DataBreg, imm_valuereg  output  DATA_W each  registered operands
RegRsreg, RegRtreg, RegRdreg  output  REG_W each  registered specifiers

Behaviour:
- Transfers: accept when in_valid&&in_ready; retire when out_valid&&out_ready.
- State machine (SKID=1): EMPTY, FULL (main entry valid), SKID (main and skid entries valid).
  - EMPTY: accept -> main<=in, go FULL.
  - FULL: accept&&retire -> main<=in, stay FULL. accept&&!retire -> skid<=in, go SKID. !accept&&retire -> EMPTY. Neither -> hold.
  - SKID: in_ready=0. retire -> main<=skid, go FULL. Otherwise hold.
- in_ready (SKID=1): registered, equal to (state!=SKID).
- SKID=0: only EMPTY and FULL exist. in_ready = out_ready || !out_valid, combinational.
- Latency: one cycle from accept in EMPTY to out_valid=1. Full throughput of 1 beat/clock when out_ready stays high.
- Output mux: outputs always show the main entry. out_valid = (state!=EMPTY).
- Bubble: when out_valid=0, WBreg/Mreg/EXreg are forced to 0 so a bubble can never write a register or memory. Data and specifier outputs keep their last loaded value.
- flush=1: next state is EMPTY and both entries are invalidated. A beat accepted in the same cycle is dropped. in_ready still follows the current-state rule during the flush cycle.
- Priority: reset over flush over normal transfer.
- Reset: state EMPTY, in_ready=1, out_valid=0. Every payload output reads 0.
- Reset mid-operation: buffered beats are lost, with no partial output.
- Ordering is strictly FIFO. No beat is duplicated or dropped except by flush or reset.
- Widths: pure storage with no arithmetic; all fields pass through bit-exact.

Decomposition:
- Shared package id_ex_pkg holds:
  - default width constants (DATA_W, REG_W, WB_W, M_W, EX_W)
  - state encoding constants EMPTY/FULL/SKID
  - a packed payload struct concatenating all fields
- One sub-module, id_ex_entry: a payload register with load enable and synchronous clear. It is instantiated as main and skid entries.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, all outputs 0.
- Streaming: out_ready=1, beats DataA=1..8 on consecutive cycles -> same values appear one cycle later, back-to-back, in_ready never drops.
- Stall: FULL with DataA=0xA, out_ready=0, send DataA=0xB -> SKID, in_ready=0 next cycle. Raise out_ready -> 0xA then 0xB retire in order.
- Bubble: EX=4'hF, WB=2'b11 beat retires, then no input -> out_valid=0, EXreg=0, WBreg=0, DataAreg unchanged.
- Flush: in SKID state with in_valid=1, pulse flush -> next cycle EMPTY, out_valid=0, none of the three beats ever retire.
- Param SKID=0: out_ready=0 while FULL -> in_ready=0 combinationally. Raise out_ready with in_valid -> simultaneous retire and accept, no lost beat.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline stage: default field widths,
// state encoding and the packed payload layout carried from decode to execute.
package id_ex_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_W  = 5;
   localparam int DEF_WB_W   = 2;
   localparam int DEF_M_W    = 3;
   localparam int DEF_EX_W   = 4;

   // Occupancy of the stage: nothing held, main entry only, main plus skid.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FULL  = 2'd1,
      S_SKID  = 2'd2
   } state_e;

   // Payload at the default widths. The stage packs its ports in this same
   // field order (control first, then operands, then specifiers).
   typedef struct packed {
      logic [DEF_WB_W-1:0]   wb;
      logic [DEF_M_W-1:0]    m;
      logic [DEF_EX_W-1:0]   ex;
      logic [DEF_DATA_W-1:0] data_a;
      logic [DEF_DATA_W-1:0] data_b;
      logic [DEF_DATA_W-1:0] imm;
      logic [DEF_REG_W-1:0]  rs;
      logic [DEF_REG_W-1:0]  rt;
      logic [DEF_REG_W-1:0]  rd;
   } payload_t;

   // Total bits of one beat for an arbitrary set of field widths.
   function automatic int payload_width(input int data_w, input int reg_w,
                                        input int wb_w, input int m_w,
                                        input int ex_w);
      return wb_w + m_w + ex_w + 3 * data_w + 3 * reg_w;
   endfunction

endpackage

// File: rtl/id_ex_entry.sv
// One payload register of the ID/EX stage: loads on demand, clears synchronously.
module id_ex_entry #(
   parameter int W = 1
) (
   input  logic         clock,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   // Next payload: clear wins over load, otherwise hold.
   always_comb begin
      // NOTE: default assigned first so every path drives data_d and no latch is inferred.
      data_d = data_q;
      if (clear) begin
         // NOTE: the payload is cleared on reset so a freshly reset stage shows all-zero outputs.
         data_d = '0;
      end else if (load) begin
         data_d = d;
      end
   end

   // Payload register.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking so every flop samples its pre-edge inputs regardless of block order.
      data_q <= data_d;
   end

   assign q = data_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage with valid/ready handshakes on both sides, an optional
// skid entry for a registered in_ready, flush to bubble, and control zeroing
// whenever no beat is presented.
module id_ex_stage
   import id_ex_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_W  = DEF_REG_W,
   parameter int WB_W   = DEF_WB_W,
   parameter int M_W    = DEF_M_W,
   parameter int EX_W   = DEF_EX_W,
   parameter int SKID   = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WB_W-1:0]   WB,
   input  logic [M_W-1:0]    M,
   input  logic [EX_W-1:0]   EX,
   input  logic [DATA_W-1:0] DataA,
   input  logic [DATA_W-1:0] DataB,
   input  logic [DATA_W-1:0] imm_value,
   input  logic [REG_W-1:0]  RegRs,
   input  logic [REG_W-1:0]  RegRt,
   input  logic [REG_W-1:0]  RegRd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WB_W-1:0]   WBreg,
   output logic [M_W-1:0]    Mreg,
   output logic [EX_W-1:0]   EXreg,
   output logic [DATA_W-1:0] DataAreg,
   output logic [DATA_W-1:0] DataBreg,
   output logic [DATA_W-1:0] imm_valuereg,
   output logic [REG_W-1:0]  RegRsreg,
   output logic [REG_W-1:0]  RegRtreg,
   output logic [REG_W-1:0]  RegRdreg
);

   localparam int PAY_W = payload_width(DATA_W, REG_W, WB_W, M_W, EX_W);

   state_e state_q;
   state_e state_d;

   logic             accept;
   logic             retire;
   logic             load_main;
   logic             load_skid;
   logic             main_from_skid;
   logic [PAY_W-1:0] in_pay;
   logic [PAY_W-1:0] main_in;
   logic [PAY_W-1:0] main_pay;
   logic [PAY_W-1:0] skid_pay;

   logic [WB_W-1:0]  wb_main;
   logic [M_W-1:0]   m_main;
   logic [EX_W-1:0]  ex_main;

   assign in_pay    = {WB, M, EX, DataA, DataB, imm_value, RegRs, RegRt, RegRd};
   assign accept    = in_valid && in_ready;
   assign retire    = out_valid && out_ready;
   assign out_valid = (state_q != S_EMPTY);

   // Next-state and entry-load decisions; flush drops everything held or arriving.
   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  load_main = 1'b1;
                  state_d   = S_FULL;
               end
            end
            S_FULL: begin
               if (accept && retire) begin
                  load_main = 1'b1;
               end else if (accept) begin
                  load_skid = 1'b1;
                  state_d   = S_SKID;
               end else if (retire) begin
                  state_d = S_EMPTY;
               end
            end
            S_SKID: begin
               if (retire) begin
                  load_main      = 1'b1;
                  main_from_skid = 1'b1;
                  state_d        = S_FULL;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   // State register; reset dominates flush and normal transfers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   assign main_in = main_from_skid ? skid_pay : in_pay;

   id_ex_entry #(.W(PAY_W)) u_main (
      .clock (clock),
      .clear (reset),
      .load  (load_main),
      .d     (main_in),
      .q     (main_pay)
   );

   id_ex_entry #(.W(PAY_W)) u_skid (
      .clock (clock),
      .clear (reset),
      .load  (load_skid),
      .d     (in_pay),
      .q     (skid_pay)
   );

   generate
      if (SKID != 0) begin : g_skid_ready
         logic in_ready_q;
         logic in_ready_d;

         // Ready for the next cycle is known from the next state alone.
         always_comb begin
            in_ready_d = (state_d != S_SKID);
         end

         // Registered in_ready breaks the ready path back into decode.
         always_ff @(posedge clock) begin
            if (reset) begin
               in_ready_q <= 1'b1;
            end else begin
               in_ready_q <= in_ready_d;
            end
         end

         assign in_ready = in_ready_q;
      end else begin : g_flow_ready
         assign in_ready = out_ready || !out_valid;
      end
   endgenerate

   assign {wb_main, m_main, ex_main, DataAreg, DataBreg, imm_valuereg,
           RegRsreg, RegRtreg, RegRdreg} = main_pay;

   // A bubble must never write a register or memory, so control reads zero.
   assign WBreg = out_valid ? wb_main : '0;
   assign Mreg  = out_valid ? m_main  : '0;
   assign EXreg = out_valid ? ex_main : '0;

endmodule
